// File: rtl/spi_ram_master_ctrl.sv
// Host-side SPI RAM master: turns single-word read/write requests into
// selector+payload frames on SS_n/MOSI and shifts read data back in from MISO.
module spi_ram_master_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int GAP_CYC   = 1,
    parameter int RD_GAP    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);
    localparam int PW = ADDR_SIZE + 2;
    localparam int FL = ADDR_SIZE + 3;
    localparam int CW = $clog2(ADDR_SIZE + GAP_CYC + RD_GAP + 4);

    localparam logic [CW-1:0] FRAME_LAST = CW'(FL - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] POST_LAST  = CW'(GAP_CYC - 2);
    localparam logic [CW-1:0] TURN_LAST  = CW'(RD_GAP - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FRAME,
        GAP,
        TURN,
        CAPTURE,
        DONE,
        POST
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   phase_reg, phase_next;
    logic                   wr_reg, wr_next;
    logic [ADDR_SIZE-1:0]   addr_reg, addr_next;
    logic [ADDR_SIZE-1:0]   wdata_reg, wdata_next;
    logic [ADDR_SIZE-1:0]   cap_reg, cap_next;
    logic [ADDR_SIZE-1:0]   rdata_reg, rdata_next;

    logic                   ss_n_reg, ss_n_next;
    logic                   mosi_reg, mosi_next;
    logic                   ready_reg, ready_next;
    logic                   rsp_valid_reg, rsp_valid_next;

    logic [PW-1:0]          payload_next;
    logic [FL-1:0]          frame_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        wr_next    = wr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cap_next   = cap_reg;
        rdata_next = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = FRAME;
                    cnt_next   = '0;
                    phase_next = 1'b0;
                    wr_next    = req_wr;
                    addr_next  = req_addr;
                    wdata_next = req_wdata;
                end
            end
            FRAME: begin
                if (cnt_reg == FRAME_LAST) begin
                    cnt_next = '0;
                    if (!phase_reg) begin
                        state_next = GAP;
                    end else if (wr_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next = TURN;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = FRAME;
                    cnt_next   = '0;
                    phase_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            TURN: begin
                if (cnt_reg == TURN_LAST) begin
                    state_next = CAPTURE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CAPTURE: begin
                // MISO is taken at the edge closing each capture cycle
                cap_next = {cap_reg[ADDR_SIZE-2:0], MISO};
                if (cnt_reg == CAP_LAST) begin
                    state_next = DONE;
                    cnt_next   = '0;
                    rdata_next = cap_next;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = (GAP_CYC > 1) ? POST : IDLE;
            end
            POST: begin
                if (cnt_reg == POST_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        if (!phase_next) begin
            payload_next = {(wr_next ? 2'b00 : 2'b10), addr_next};
        end else if (wr_next) begin
            payload_next = {2'b01, wdata_next};
        end else begin
            payload_next = {2'b11, {ADDR_SIZE{1'b0}}};
        end
    end

    // Selector bit leads the payload; outputs are registered from the next state
    assign frame_next     = {payload_next[PW-1], payload_next} << cnt_next;
    assign ss_n_next      = !((state_next == FRAME) || (state_next == TURN) ||
                              (state_next == CAPTURE));
    assign mosi_next      = (state_next == FRAME) && frame_next[FL-1];
    assign ready_next     = (state_next == IDLE);
    assign rsp_valid_next = (state_next == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            phase_reg     <= 1'b0;
            wr_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cap_reg       <= '0;
            rdata_reg     <= '0;
            ss_n_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            wr_reg        <= wr_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            cap_reg       <= cap_next;
            rdata_reg     <= rdata_next;
            ss_n_reg      <= ss_n_next;
            mosi_reg      <= mosi_next;
            ready_reg     <= ready_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    assign req_ready = ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rdata_reg;
    assign SS_n      = ss_n_reg;
    assign MOSI      = mosi_reg;

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Directed bench: two controllers (default and GAP_CYC=3/RD_GAP=4), each with
// a small behavioural SPI RAM wrapper model on its serial pins.
module tb_spi_ram_master_ctrl;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic       req_valid_s [2];
    logic       req_ready_s [2];
    logic       req_wr_s    [2];
    logic [7:0] req_addr_s  [2];
    logic [7:0] req_wdata_s [2];
    logic       rsp_valid_s [2];
    logic [7:0] rsp_rdata_s [2];
    logic       ss_n_s      [2];
    logic       mosi_s      [2];
    logic       miso_s      [2];

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic ss_log   [64];
    logic mosi_log [64];

    logic [7:0] mem     [2][256];
    logic [7:0] maddr   [2];
    logic [9:0] msh     [2];
    logic [7:0] rd_word [2];
    logic       rd_on   [2];
    int         mcnt    [2];
    int         hi_run  [2];
    int         rsp_cnt [2];
    int         gap_viol = 0;

    spi_ram_master_ctrl #(.ADDR_SIZE(8), .GAP_CYC(1), .RD_GAP(2)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_wr(req_wr_s[0]),
        .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]),
        .rsp_valid(rsp_valid_s[0]), .rsp_rdata(rsp_rdata_s[0]),
        .SS_n(ss_n_s[0]), .MOSI(mosi_s[0]), .MISO(miso_s[0])
    );

    spi_ram_master_ctrl #(.ADDR_SIZE(8), .GAP_CYC(3), .RD_GAP(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_wr(req_wr_s[1]),
        .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_rdata(rsp_rdata_s[1]),
        .SS_n(ss_n_s[1]), .MOSI(mosi_s[1]), .MISO(miso_s[1])
    );

    always #5 clk = ~clk;

    function automatic int gap_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int rd_gap_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    // RAM wrapper model plus SS_n gap and response monitors, all mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int         base;
            int         sh_amt;
            logic [7:0] tmp;
            if (!rst_n || ss_n_s[k]) begin
                mcnt[k]   = 0;
                miso_s[k] = 1'b0;
                rd_on[k]  = 1'b0;
            end else begin
                mcnt[k] = mcnt[k] + 1;
                if (mcnt[k] >= 2 && mcnt[k] <= W + 3) begin
                    msh[k] = {msh[k][8:0], mosi_s[k]};
                end
                if (mcnt[k] == W + 3) begin
                    case (msh[k][9:8])
                        2'b00: maddr[k] = msh[k][7:0];
                        2'b01: mem[k][maddr[k]] = msh[k][7:0];
                        2'b10: maddr[k] = msh[k][7:0];
                        default: begin
                            rd_on[k]   = 1'b1;
                            rd_word[k] = mem[k][maddr[k]];
                        end
                    endcase
                end
                base = W + 4 + rd_gap_of(k);
                if (rd_on[k] && mcnt[k] >= base && mcnt[k] < base + W) begin
                    sh_amt    = W - 1 - (mcnt[k] - base);
                    tmp       = rd_word[k] >> sh_amt;
                    miso_s[k] = tmp[0];
                end else begin
                    miso_s[k] = 1'b0;
                end
            end
            if (ss_n_s[k]) begin
                hi_run[k] = hi_run[k] + 1;
            end else begin
                if (hi_run[k] > 0 && hi_run[k] < gap_of(k)) gap_viol = gap_viol + 1;
                hi_run[k] = 0;
            end
            if (rsp_valid_s[k]) rsp_cnt[k] = rsp_cnt[k] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [63:0] pack_log(input int lo, input int hi, input bit use_ss);
        logic [63:0] v;
        v = '0;
        for (int c = lo; c <= hi; c++) v = {v[62:0], (use_ss ? ss_log[c] : mosi_log[c])};
        return v;
    endfunction

    // Issues one request; cycle 1 is the cycle after the acceptance edge
    task automatic run_op(input int k, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input logic hold,
                          output int wait_cyc, output int rsp_cyc, output logic [7:0] rd);
        int n;
        for (int c = 0; c < 64; c++) begin
            ss_log[c]   = 1'bx;
            mosi_log[c] = 1'bx;
        end
        @(negedge clk);
        req_valid_s[k] = 1'b1;
        req_wr_s[k]    = wr;
        req_addr_s[k]  = a;
        req_wdata_s[k] = d;
        n = 0;
        while (!req_ready_s[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        wait_cyc = n;
        rsp_cyc  = -1;
        rd       = '0;
        if (req_ready_s[k]) begin
            @(posedge clk);
            #1;
            if (!hold) req_valid_s[k] = 1'b0;
            for (int c = 1; c < 64; c++) begin
                @(negedge clk);
                ss_log[c]   = ss_n_s[k];
                mosi_log[c] = mosi_s[k];
                if (rsp_valid_s[k]) begin
                    rsp_cyc = c;
                    rd      = rsp_rdata_s[k];
                    break;
                end
            end
        end else begin
            req_valid_s[k] = 1'b0;
        end
        $display("op inst=%0d wr=%0d addr=0x%02h wdata=0x%02h wait=%0d rsp_cyc=%0d rdata=0x%02h",
                 k, wr, a, d, wait_cyc, rsp_cyc, rd);
    endtask

    initial begin
        int         w_cyc;
        int         r_cyc;
        logic [7:0] rd;
        int         n;
        int         rsp_before;

        clk   = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid_s[k] = 1'b0;
            req_wr_s[k]    = 1'b0;
            req_addr_s[k]  = '0;
            req_wdata_s[k] = '0;
            maddr[k]       = '0;
            msh[k]         = '0;
            rd_word[k]     = '0;
            rd_on[k]       = 1'b0;
            mcnt[k]        = 0;
            hi_run[k]      = 100;
            rsp_cnt[k]     = 0;
            for (int a = 0; a < 256; a++) mem[k][a] = '0;
        end

        // 1: reset state
        #3 rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_ss_n", ss_n_s[0], 1);
        check_val("rst_mosi", mosi_s[0], 0);
        check_val("rst_ready", req_ready_s[0], 1);
        check_val("rst_rsp_valid", rsp_valid_s[0], 0);
        check_val("rst_rdata", rsp_rdata_s[0], 8'h00);
        check_val("rst_ss_n_g3", ss_n_s[1], 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 2: write 0xA5 -> 0x3C
        run_op(0, 1'b1, 8'h3C, 8'hA5, 1'b0, w_cyc, r_cyc, rd);
        check_val("wr_rsp_cyc", 64'(r_cyc), 24);
        check_val("wr_mosi", pack_log(1, 23, 1'b0), {11'b00000111100, 1'b0, 11'b00110100101});
        check_val("wr_ss_n", pack_log(1, 24, 1'b1), {11'b0, 1'b1, 11'b0, 1'b1});
        check_val("wr_rdata_hold", rd, 8'h00);

        // 3: read 0x3C
        run_op(0, 1'b0, 8'h3C, 8'h00, 1'b0, w_cyc, r_cyc, rd);
        check_val("rd_rsp_cyc", 64'(r_cyc), 34);
        check_val("rd_rdata", rd, 8'hA5);
        check_val("rd_mosi", pack_log(1, 33, 1'b0),
                  {11'b11000111100, 1'b0, 11'b11100000000, 10'b0});
        check_val("rd_ss_n", pack_log(1, 34, 1'b1), {11'b0, 1'b1, 21'b0, 1'b1});

        // 4: back-to-back write 0xFF -> 0x00 then read 0x00, valid held high
        run_op(0, 1'b1, 8'h00, 8'hFF, 1'b1, w_cyc, r_cyc, rd);
        check_val("b2b_wr_rsp_cyc", 64'(r_cyc), 24);
        check_val("b2b_wr_mosi", pack_log(1, 23, 1'b0), {11'b0, 1'b0, 11'b00111111111});
        run_op(0, 1'b0, 8'h00, 8'h00, 1'b0, w_cyc, r_cyc, rd);
        check_val("b2b_accept_wait", 64'(w_cyc), 0);
        check_val("b2b_rd_rsp_cyc", 64'(r_cyc), 34);
        check_val("b2b_rd_rdata", rd, 8'hFF);

        // 5: reset during the capture phase of a read
        @(negedge clk);
        req_valid_s[0] = 1'b1;
        req_wr_s[0]    = 1'b0;
        req_addr_s[0]  = 8'h00;
        n = 0;
        while (!req_ready_s[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_ready_wait", 64'(n), 0);
        @(posedge clk);
        #1 req_valid_s[0] = 1'b0;
        rsp_before = rsp_cnt[0];
        repeat (27) @(posedge clk);
        #2;
        check_val("abort_ss_pre", ss_n_s[0], 0);
        rst_n = 1'b0;
        #1;
        check_val("abort_ss_n", ss_n_s[0], 1);
        check_val("abort_rsp_valid", rsp_valid_s[0], 0);
        check_val("abort_ready", req_ready_s[0], 1);
        check_val("abort_rdata", rsp_rdata_s[0], 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_val("abort_no_rsp", 64'(rsp_cnt[0] - rsp_before), 0);
        run_op(0, 1'b0, 8'h00, 8'h00, 1'b0, w_cyc, r_cyc, rd);
        check_val("post_abort_rsp_cyc", 64'(r_cyc), 34);
        check_val("post_abort_rdata", rd, 8'hFF);

        // 6: GAP_CYC=3, RD_GAP=4 instance; request held through the busy period
        run_op(1, 1'b1, 8'h10, 8'h5A, 1'b1, w_cyc, r_cyc, rd);
        req_valid_s[1] = 1'b0;
        check_val("g3_wr_rsp_cyc", 64'(r_cyc), 26);
        check_val("g3_wr_mosi", pack_log(1, 25, 1'b0),
                  {11'b00000010000, 3'b000, 11'b00101011010});
        @(negedge clk);
        check_val("g3_ready_c27", req_ready_s[1], 0);
        @(negedge clk);
        check_val("g3_ready_c28", req_ready_s[1], 0);
        @(negedge clk);
        check_val("g3_ready_c29", req_ready_s[1], 1);
        repeat (5) @(negedge clk);
        check_val("g3_busy_ignored_ss", ss_n_s[1], 1);
        check_val("g3_busy_ignored_ready", req_ready_s[1], 1);
        run_op(1, 1'b0, 8'h10, 8'h00, 1'b0, w_cyc, r_cyc, rd);
        check_val("g3_rd_rsp_cyc", 64'(r_cyc), 38);
        check_val("g3_rd_rdata", rd, 8'h5A);
        check_val("g3_rd_ss_n", pack_log(1, 38, 1'b1), {11'b0, 3'b111, 23'b0, 1'b1});

        repeat (3) @(negedge clk);
        check_val("ss_gap_viol", 64'(gap_viol), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/spi_ram_master_ctrl.md
Name: spi_ram_master_ctrl

Overview:
Host-side controller that turns single-word RAM read/write requests into the serial frame sequence the SPI RAM wrapper accepts.
- Drives SS_n and MOSI and samples MISO, all on the same system clock as the slave.
- Returns read data and write acknowledges to the requester over a valid/ready request and pulse-response interface.
- Sits between the on-chip host logic and the SPI RAM wrapper's serial pins.

Parameters:
ADDR_SIZE, 8, address and data word width; a frame payload is ADDR_SIZE+2 bits.
GAP_CYC, 1, SS_n-high idle cycles between consecutive frames and after each operation (min 1).
RD_GAP, 2, cycles between the end of the read-data command frame and the first MISO sample (min 1).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller idle and able to accept a request.
req_wr  input  1  1 = write, 0 = read.
req_addr  input  ADDR_SIZE  RAM address.
req_wdata  input  ADDR_SIZE  write data (ignored for reads).
rsp_valid  output  1  one-cycle pulse: operation complete.
rsp_rdata  output  ADDR_SIZE  read data, valid with rsp_valid; holds last value otherwise; unchanged by writes.
SS_n  output  1  slave select to RAM wrapper, active low.
MOSI  output  1  serial data to RAM wrapper.
MISO  input  1  serial data from RAM wrapper.

Behaviour:
Reset (async, rst_n=0):
- SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0, FSM=IDLE, counters=0.
- Asserting rst_n mid-frame aborts the operation immediately (SS_n rises asynchronously). No rsp_valid is issued for the aborted operation.

Outputs:
- All outputs are registered.
- Acceptance: req_valid && req_ready on rising edge of clk = cycle 0. req/addr/wdata are captured into internal registers. req_ready drops in cycle 1.

Frame format:
- Payload P is ADDR_SIZE+2 bits: P[ADDR_SIZE+1:ADDR_SIZE] = cmd, P[ADDR_SIZE-1:0] = word.
- cmd encoding: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data (word = 0).
- First SS_n-low cycle: MOSI = P[ADDR_SIZE+1] (selector bit). Next ADDR_SIZE+2 cycles: MOSI = P MSB-first.
- Total SS_n-low span = ADDR_SIZE+3 cycles (11 at default).
- After a non-read-data frame: SS_n=1 for GAP_CYC cycles, MOSI=0.

Operation sequences:
- Write = frame {00,addr}, gap, frame {01,wdata}.
- Read = frame {10,addr}, gap, frame {11,0}.
  - SS_n then stays low for RD_GAP cycles.
  - Then 8 (ADDR_SIZE) cycles sample MISO MSB-first into a shift register.

FSM: IDLE -> FRAME -> GAP -> FRAME -> (write: DONE | read: TURN -> CAPTURE -> DONE).
- DONE: SS_n=1, rsp_valid=1 for exactly one cycle. rsp_rdata updated only on reads.
- Then GAP_CYC-1 further idle cycles (none at GAP_CYC=1), then IDLE with req_ready=1.
- At defaults, req_ready reasserts in the cycle after DONE.

Latency (defaults, G=GAP_CYC, R=RD_GAP, W=ADDR_SIZE):
- Write: first frame cycles 1..11, second frame cycles 12+G..22+G, rsp_valid at cycle 23+G (24).
- Read: second frame cycles 12+G..22+G, turnaround 23+G..22+G+R, samples 23+G+R..30+G+R, rsp_valid at 31+G+R (34).

Edge cases:
- req_valid while req_ready=0: ignored; no queueing.
- A back-to-back request is accepted in the first IDLE cycle. SS_n high time between operations is always at least GAP_CYC.
- rsp_valid has no backpressure.
- Address 0 and all-ones addresses/data are transmitted unmodified; no wrap or saturation logic.

Test Plan:
1. Reset check: assert rst_n=0 at arbitrary time -> SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=0x00.
2. Write addr=0x3C, data=0xA5:
   - MOSI frame 1 = 0,0,0,0,0,1,1,1,1,0,0.
   - Frame 2 = 0,0,1,1,0,1,0,0,1,0,1.
   - SS_n high exactly 1 cycle between frames; rsp_valid at cycle 24; rsp_rdata unchanged.
3. Read addr=0x3C after step 2, with RAM wrapper model attached:
   - Frames {10,0x3C} and {11,0x00} sent.
   - rsp_valid at cycle 34 with rsp_rdata=0xA5.
4. Back-to-back: write 0xFF->0x00, then read 0x00 with req_valid held high -> second request accepted in first idle cycle; rsp_rdata=0xFF; SS_n never low across operations without at least a 1-cycle high gap.
5. Reset mid-operation: rst_n=0 during read CAPTURE -> SS_n=1 immediately, no rsp_valid. A subsequent read 0x00 returns 0xFF.
6. Parameter sweep GAP_CYC=3, RD_GAP=4: write rsp_valid at cycle 26; read rsp_valid at cycle 38; req_valid while busy ignored.
